// File: rtl/ff_mode_ctrl.sv
// Two-requester controller for a WIDTH-bit JK flip-flop register: round-robin
// arbitration, one load/toggle/set/clear operation per IDLE->APPLY->DONE pass.
module ff_mode_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       mode0,
    input  logic [WIDTH-1:0] d0,
    input  logic [1:0]       mode1,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_TOGGLE = 2'b01,
        OP_SET    = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       ack_q, ack_d;
    logic             ptr_q, ptr_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             win;
    logic [WIDTH-1:0] j, k;

    // Per-bit J/K drive derived from the latched operation and operand.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        j = '0;
        k = '0;
        case (op_q)
            OP_LOAD:   begin j = opnd_q;  k = ~opnd_q; end
            OP_TOGGLE: begin j = opnd_q;  k = opnd_q;  end
            OP_SET:    begin j = opnd_q;  k = '0;      end
            OP_CLEAR:  begin j = '0;      k = opnd_q;  end
            default:   begin j = '0;      k = '0;      end
        endcase
    end

    // A lone requester always wins; on contention the pointer holder wins.
    assign win = (req == 2'b11) ? ptr_q : req[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                ack_d = 2'b00;
                if (req != 2'b00) begin
                    state_d = APPLY;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    op_d    = op_e'(win ? mode1 : mode0);
                    opnd_d  = win ? d1 : d0;
                    ptr_d   = ~win;
                end
            end
            APPLY: begin
                // JK characteristic equation: q+ = J&~q | ~K&q.
                q_d     = (j & ~q_q) | (~k & q_q);
                ack_d   = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                ack_d   = 2'b00;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                ack_d   = 2'b00;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            ptr_q   <= 1'b0;
            // NOTE: latched operation/operand are reset too, so an aborted request leaves nothing behind.
            op_q    <= OP_LOAD;
            opnd_q  <= '0;
            q_q     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            q_q     <= q_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign busy = (state_q != IDLE);
    assign q    = q_q;
    assign qb   = ~q_q;

endmodule

// File: tb/tb_ff_mode_ctrl.sv
// Scoreboard bench for ff_mode_ctrl: driver pushes predicted completions,
// a negedge monitor pops them on ack and checks q/qb/gnt/busy every cycle.
module tb_ff_mode_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   mode0;
    logic [W-1:0] d0;
    logic [1:0]   mode1;
    logic [W-1:0] d1;
    logic [1:0]   gnt;
    logic [1:0]   ack;
    logic         busy;
    logic [W-1:0] q;
    logic [W-1:0] qb;

    ff_mode_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .mode0 (mode0),
        .d0    (d0),
        .mode1 (mode1),
        .d1    (d1),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .q     (q),
        .qb    (qb)
    );

    typedef struct {
        logic [1:0]   ack;
        logic [W-1:0] q;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;

    // Reference state: register contents after all accepted ops, and the
    // requester that wins the next tie.
    logic [W-1:0] model_q  = '0;
    int           ptr      = 0;
    logic [1:0]   exp_gnt  = 2'b00;
    logic         exp_busy = 1'b0;

    initial begin
        clk = 1'b0;
        #3;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] m, input logic [W-1:0] d,
                                            input logic [W-1:0] cur);
        case (m)
            2'd0:    return d;
            2'd1:    return cur ^ d;
            2'd2:    return cur | d;
            default: return cur & ~d;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        req   = 2'($urandom_range(0, 3));
        mode0 = 2'($urandom_range(0, 3));
        mode1 = 2'($urandom_range(0, 3));
        d0    = W'($urandom);
        d1    = W'($urandom);
    endtask

    // One arbitration slot: drive the request, predict the outcome, and run
    // through APPLY/DONE (optionally wiggling inputs that must be ignored).
    task automatic do_op(input logic [1:0] r, input logic [1:0] m0, input logic [W-1:0] dd0,
                         input logic [1:0] m1, input logic [W-1:0] dd1, input bit scramble);
        int         winner;
        logic [1:0] m;
        logic [W-1:0] d;
        exp_t       e;
        req   = r;
        mode0 = m0;
        d0    = dd0;
        mode1 = m1;
        d1    = dd1;
        winner = 0;
        if (r != 2'b00) begin
            if (r == 2'b11) winner = ptr;
            else            winner = r[1] ? 1 : 0;
            m       = (winner == 1) ? m1 : m0;
            d       = (winner == 1) ? dd1 : dd0;
            model_q = ref_op(m, d, model_q);
            e.ack   = 2'b01 << winner;
            e.q     = model_q;
            sb.push_back(e);
            ptr     = 1 - winner;
        end
        cycle();
        if (r != 2'b00) begin
            exp_gnt  = 2'b01 << winner;
            exp_busy = 1'b1;
            if (scramble) scramble_inputs();
            cycle();
            if (scramble) scramble_inputs();
            cycle();
            exp_gnt  = 2'b00;
            exp_busy = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        rst      = 1'b1;
        req      = 2'b00;
        sb.delete();
        model_q  = '0;
        ptr      = 0;
        exp_gnt  = 2'b00;
        exp_busy = 1'b0;
        cycle();
        rst      = 1'b0;
    endtask

    // Monitor: consumes one expectation per ack pulse and checks outputs each cycle.
    initial begin
        logic [W-1:0] cur_q;
        logic [W-1:0] cur_qb;
        exp_t         e;
        cur_q = '0;
        forever begin
            @(negedge clk);
            if (rst) cur_q = '0;
            if (ack != 2'b00) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack", 32'(ack), 32'(e.ack));
                    cur_q = e.q;
                end
            end else if (!rst) begin
                check("ack_idle", 32'(ack), 32'd0);
            end
            cur_qb = ~cur_q;
            check("q", 32'(q), 32'(cur_q));
            check("qb", 32'(qb), 32'(cur_qb));
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("busy", 32'(busy), 32'(exp_busy));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        req   = 2'b11;
        mode0 = 2'b00;
        mode1 = 2'b00;
        d0    = '0;
        d1    = '0;
        #15;
        rst   = 1'b0;

        // Single requester 0: load, toggle, set, clear.
        do_op(2'b01, 2'd0, 4'hA, 2'd0, 4'h0, 1'b1);
        do_op(2'b01, 2'd1, 4'hF, 2'd0, 4'h0, 1'b1);
        do_op(2'b01, 2'd2, 4'h8, 2'd0, 4'h0, 1'b1);
        do_op(2'b01, 2'd3, 4'h4, 2'd0, 4'h0, 1'b1);
        check("chain_q", 32'(q), 32'h9);
        do_op(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 1'b0);

        // Contention straight after reset: requester 0 first, then 1.
        reset_pulse();
        do_op(2'b11, 2'd0, 4'h3, 2'd0, 4'hC, 1'b0);
        do_op(2'b11, 2'd0, 4'h3, 2'd0, 4'hC, 1'b0);
        check("contention_q", 32'(q), 32'hC);

        // Held contention: grants must alternate.
        for (int i = 0; i < 4; i++) do_op(2'b11, 2'd1, 4'h5, 2'd2, 4'h2, 1'b0);
        do_op(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 1'b0);

        // Abort: reset during APPLY of load 7.
        begin
            exp_t e;
            req   = 2'b01;
            mode0 = 2'd0;
            d0    = 4'h7;
            e.ack = 2'b01;
            e.q   = 4'h7;
            sb.push_back(e);
            cycle();
            exp_gnt  = 2'b01;
            exp_busy = 1'b1;
            reset_pulse();
            check("abort_q", 32'(q), 32'h0);
        end
        do_op(2'b10, 2'd0, 4'h0, 2'd0, 4'h5, 1'b1);
        check("after_abort_q", 32'(q), 32'h5);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), W'($urandom),
                  2'($urandom_range(0, 3)), W'($urandom), 1'($urandom_range(0, 1)));
        end

        req = 2'b00;
        cycle();
        cycle();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ff_mode_ctrl.md
FF_MODE_CTRL -- requirements
Module: ff_mode_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the managed JK flip-flop register.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  request lines; req[i] high = requester i wants one register operation.
REQ-005 mode0  input  2  requester 0 operation: 00 load(D), 01 toggle(T), 10 set, 11 clear.
REQ-006 d0  input  WIDTH  requester 0 operand vector.
REQ-007 mode1  input  2  requester 1 operation, same encoding as mode0.
REQ-008 d1  input  WIDTH  requester 1 operand vector.
REQ-009 gnt  output  2  one-hot registered grant; identifies the requester being served.
REQ-010 ack  output  2  one-cycle completion pulse to the served requester.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 q  output  WIDTH  JK flip-flop register contents.
REQ-013 qb  output  WIDTH  bitwise complement of q at all times.

Function
REQ-014 Register SHALL be WIDTH JK flip-flops; every update goes through per-bit J/K: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-015 J/K mapping per bit, operand bit d: load J=d,K=~d; toggle J=d,K=d; set J=d,K=0; clear J=0,K=d.
REQ-016 Resulting q: load q=d; toggle q=q^d; set q=q|d; clear q=q&~d.
REQ-017 FSM states: IDLE, APPLY, DONE; encoding free.
REQ-018 IDLE: if req!=0 at rising edge, go APPLY, register gnt, latch winner's mode and operand; else stay IDLE, gnt=0.
REQ-019 APPLY: at next edge update q from latched mode/operand, go DONE, set ack[g]=1 for the granted g.
REQ-020 DONE: at next edge clear ack and gnt, go IDLE; no arbitration in DONE.
REQ-021 Latency: req sampled at edge E0 -> q updated and ack high after E1 -> ack low, busy low after E2; max throughput one op per 3 cycles.
REQ-022 Operands latched in IDLE; changes to mode/d during APPLY/DONE SHALL have no effect on the current operation.
REQ-023 Arbitration round-robin: pointer names highest-priority requester; after serving i, pointer = other requester.
REQ-024 Both req high in IDLE: pointer holder wins; the other stays pending and is served next if still requesting.
REQ-025 Requester drops req in cycle after ack; req still high when FSM returns to IDLE = new request.
REQ-026 req deasserted after acceptance SHALL NOT cancel the operation; ack still issued.
REQ-027 q SHALL change only on the APPLY->DONE edge or on reset.
REQ-028 gnt and ack SHALL be one-hot or zero; ack[i] only while gnt[i].

Reset
REQ-029 rst high forces immediately: q=0, qb=all ones, state IDLE, gnt=0, ack=0, busy=0, pointer=requester 0.
REQ-030 Reset mid-operation SHALL abort with no ack and no q update; latched operands discarded.
REQ-031 First arbitration after reset release occurs at the first rising edge with rst low.

Verification
REQ-032 Reset: rst=1 for 15 time units with req=2'b11 -> q=0, qb=F, gnt=0, ack=0 throughout.
REQ-033 Load: WIDTH=4, req=01, mode0=00, d0=4'hA -> gnt=01 one edge later, q=A and ack=01 next edge, busy low after third edge.
REQ-034 Toggle/set/clear: from q=A, req0 toggle d=F -> q=5; set d=8 -> q=D; clear d=4 -> q=9; qb always ~q.
REQ-035 Contention: after reset req=11, req0 load 3, req1 load C held -> served order 0 then 1; final q=C; ack pulses 01 then 10, 3 cycles apart.
REQ-036 Fairness: req=11 held for 12 cycles -> grants alternate 01,10,01,10; neither served twice in a row.
REQ-037 Abort: rst pulsed during APPLY of load 7 -> no ack, q=0, next request completes normally.
